sad_accumulator: RTL
====================

Name: sad_accumulator

Overview:
- Multi-lane, pipelined absolute-difference accumulator built on the CLA subtract/negate datapath.
- Each accepted sample carries LANES operand pairs. The block computes |A-B| per lane and reduces over a frame of FRAME_LEN samples to either a sum (SAD) or a running maximum.
- Result is delivered on a valid/ready output port.
- Sits between the operand source and any consumer needing a frame distance metric (motion match, error metric).

Parameters:
- N, 8, operand width per lane (unsigned).
- LANES, 4, operand pairs per sample.
- FRAME_LEN, 16, samples per frame (>=1).
- ACC_W, derived localparam N+$clog2(LANES*FRAME_LEN), result width; not overridable.
- CNT_W, derived localparam $clog2(LANES*FRAME_LEN+1), GE counter width.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  sample valid.
- IN_READY  out  1  block accepts sample this cycle.
- A  in  LANES*N  lane operands; lane k at [k*N +: N].
- B  in  LANES*N  lane operands, same packing.
- MODE  in  1  0 = sum of |A-B|, 1 = max of |A-B|; latched on first sample of frame.
- ABORT  in  1  synchronous frame discard.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts result.
- OUT_RES  out  ACC_W  SAD, or max zero-extended.
- OUT_GE_CNT  out  CNT_W  count of lane-samples in frame with A>=B.

Behaviour:
- Reset (async, RST_N=0): state=ACCUM, sample count=0, accumulator=0, pipeline valid=0, OUT_VALID=0, OUT_RES=0, OUT_GE_CNT=0, latched mode=0. IN_READY=1 as soon as RST_N=1.
- Accept = IN_VALID & IN_READY at a rising edge.
- Stage 1: at the accept edge, register per-lane |A-B| and A>=B flags. A==B gives diff 0, flag 1.
- Stage 2: on the next edge, fold the registered lanes into the accumulator and GE counter.
- States:
  - ACCUM: IN_READY=1. On each accept, count+1. The accept of sample FRAME_LEN goes to DRAIN.
  - DRAIN: IN_READY=0. Waits one edge for stage 2 to complete, then goes to DONE.
  - DONE: IN_READY=0, OUT_VALID=1, OUT_RES/OUT_GE_CNT stable. OUT_VALID&OUT_READY at an edge clears accumulator, counter and count, and returns to ACCUM.
- Latency: OUT_VALID is high after the 2nd rising edge following the edge that accepted the last sample.
- Mode 0: OUT_RES = sum over all lanes and samples. ACC_W guarantees no overflow; no saturation logic.
- Mode 1: OUT_RES = max over all lanes and samples.
- MODE is sampled on the frame's first accept; MODE changes mid-frame are ignored.
- Back-to-back: the first sample of the next frame is accepted on the cycle after the output handshake (IN_READY is registered from state). No overlap of frames.
- ABORT=1 at an edge (any state) forces ACCUM, clears count, accumulator, GE counter and pipeline valid, and drops OUT_VALID. Same-cycle IN_VALID is discarded; ABORT wins over the output handshake.
- FRAME_LEN=1: ACCUM goes to DRAIN on the first accept.
- IN_VALID while IN_READY=0 is ignored and not stored.
- RST_N asserted mid-frame or in DONE: outputs take reset values immediately and the partial frame is lost.

Decomposition:
- Package sad_pkg:
  - state enum {ACCUM, DRAIN, DONE}.
  - mode enum {MODE_SUM=0, MODE_MAX=1}.
  - function for ACC_W/CNT_W from N, LANES, FRAME_LEN.
- Sub-module lane_absdiff (param N): combinational |a-b| and a_ge_b.
  - Built from the existing CLA: subtract, then conditional two's-complement negate when borrow.
  - Instantiated LANES times via generate.
- Lane reduction tree and FSM stay in sad_accumulator.

Test Plan (N=8, LANES=4, FRAME_LEN=4 unless noted; ACC_W=12, CNT_W=5):
1. All lanes A=10, B=3, 4 samples, MODE=0 -> OUT_RES=112, OUT_GE_CNT=16, OUT_VALID 2 edges after 4th accept.
2. All lanes A=3, B=10, MODE=0 -> OUT_RES=112, OUT_GE_CNT=0. A=B=77 frame -> OUT_RES=0, OUT_GE_CNT=16.
3. All lanes A=255, B=0, MODE=0 -> OUT_RES=4080, no overflow.
4. MODE=1, one lane-sample A=250/B=50, others A=5/B=9; MODE toggled to 0 mid-frame -> OUT_RES=200.
5. OUT_READY low 5 cycles in DONE, IN_VALID held 1 -> OUT_VALID/OUT_RES stable, IN_READY=0, no sample counted. Next frame starts cleanly after handshake.
6. Two cases:
   - ABORT after 2 accepts, then full frame A=1/B=0 -> OUT_RES=16, OUT_GE_CNT=16.
   - RST_N low for 1 cycle mid-frame -> all outputs reset immediately, IN_READY=1 after release.

Source files
------------

// File: rtl/sad_pkg.sv
// Shared types and width helpers for the multi-lane SAD / max accumulator.
package sad_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic {
        MODE_SUM = 1'b0,
        MODE_MAX = 1'b1
    } mode_e;

    function automatic int acc_w(input int n, input int lanes, input int flen);
        return n + $clog2(lanes * flen);
    endfunction

    function automatic int cnt_w(input int lanes, input int flen);
        return $clog2(lanes * flen + 1);
    endfunction

endpackage

// File: rtl/lane_absdiff.sv
// One lane of |a-b|: carry-lookahead subtract a+~b+1, then negate on borrow.
module lane_absdiff #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] diff_o,
    output logic         a_ge_b_o
);

    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N-1:0] d;
    logic [N:0]   c;

    always_comb begin
        g    = a_i & ~b_i;
        p    = a_i ^ ~b_i;
        c    = '0;
        c[0] = 1'b1;
        for (int i = 0; i < N; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        d        = p ^ c[N-1:0];
        // Carry out of a+~b+1 is the "no borrow" flag, i.e. a >= b.
        a_ge_b_o = c[N];
        diff_o   = c[N] ? d : (~d + N'(1));
    end

endmodule

// File: rtl/sad_accumulator.sv
// Frame-based |A-B| accumulator: per-lane diff stage, fold stage, small FSM.
module sad_accumulator
    import sad_pkg::*;
#(
    parameter  int N         = 8,
    parameter  int LANES     = 4,
    parameter  int FRAME_LEN = 16,
    localparam int ACC_W     = acc_w(N, LANES, FRAME_LEN),
    localparam int CNT_W     = cnt_w(LANES, FRAME_LEN)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [LANES*N-1:0] A,
    input  logic [LANES*N-1:0] B,
    input  logic               MODE,
    input  logic               ABORT,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [ACC_W-1:0]   OUT_RES,
    output logic [CNT_W-1:0]   OUT_GE_CNT
);

    localparam int SCNT_W = $clog2(FRAME_LEN + 1);

    logic [N-1:0]     diff_w [LANES];
    logic [LANES-1:0] ge_w;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        lane_absdiff #(.N(N)) u_lane (
            .a_i      (A[k*N +: N]),
            .b_i      (B[k*N +: N]),
            .diff_o   (diff_w[k]),
            .a_ge_b_o (ge_w[k])
        );
    end

    logic [N-1:0]      diff_q [LANES];
    logic [LANES-1:0]  ge_q;
    logic              pv_q, pv_d;
    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [SCNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  gec_q, gec_d;
    logic              accept;

    logic [ACC_W-1:0]  lane_sum;
    logic [N-1:0]      lane_max;
    logic [CNT_W-1:0]  lane_ge;

    assign IN_READY   = (state_q == ACCUM);
    assign OUT_VALID  = (state_q == DONE);
    assign OUT_RES    = acc_q;
    assign OUT_GE_CNT = gec_q;
    assign accept     = IN_VALID & IN_READY & ~ABORT;

    always_comb begin
        lane_sum = '0;
        lane_max = '0;
        lane_ge  = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum = lane_sum + ACC_W'(diff_q[k]);
            if (diff_q[k] > lane_max) begin
                lane_max = diff_q[k];
            end
            lane_ge = lane_ge + CNT_W'(ge_q[k]);
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        gec_d   = gec_q;
        pv_d    = 1'b0;
        if (pv_q) begin
            gec_d = gec_q + lane_ge;
            if (mode_q == MODE_MAX) begin
                if (ACC_W'(lane_max) > acc_q) begin
                    acc_d = ACC_W'(lane_max);
                end
            end else begin
                acc_d = acc_q + lane_sum;
            end
        end
        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    pv_d  = 1'b1;
                    cnt_d = cnt_q + SCNT_W'(1);
                    if (cnt_q == '0) begin
                        mode_d = mode_e'(MODE);
                    end
                    if (cnt_q == SCNT_W'(FRAME_LEN - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            // Leave DRAIN only once the last sample has been folded.
            DRAIN: begin
                if (!pv_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                    acc_d   = '0;
                    gec_d   = '0;
                end
            end
            default: state_d = ACCUM;
        endcase
        if (ABORT) begin
            state_d = ACCUM;
            cnt_d   = '0;
            acc_d   = '0;
            gec_d   = '0;
            pv_d    = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ACCUM;
            mode_q  <= MODE_SUM;
            cnt_q   <= '0;
            acc_q   <= '0;
            gec_q   <= '0;
            pv_q    <= 1'b0;
            ge_q    <= '0;
            for (int k = 0; k < LANES; k++) begin
                diff_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            gec_q   <= gec_d;
            pv_q    <= pv_d;
            if (accept) begin
                ge_q <= ge_w;
                for (int k = 0; k < LANES; k++) begin
                    diff_q[k] <= diff_w[k];
                end
            end
        end
    end

endmodule
